dt_ensemble_engine: RTL and testbench

- Parametrised successor to the 3-stage decision-tree classifier.
- Evaluates an ensemble of NUM_TREES binary decision trees over one feature vector and returns the majority-vote class.
- Adds over the previous generation: multibit class labels, configurable feature width and count, a per-tree root table, a depth guard with an error flag, and valid/ready backpressure on the output.
- Sits between the host feature loader and the result collector. Node storage is internal register arrays, so no SRAM macros are needed.

---
 rtl/dt_ensemble_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_dt_ensemble_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_ensemble_engine.sv
// -----------------------------------------------------------------------------
// dt_ensemble_engine
//
// Evaluates an ensemble of NUM_TREES binary decision trees over one feature
// vector and returns the majority-vote class. Node and root tables are
// internal register arrays written through the config port while idle.
// One internal node is visited per cycle. A depth guard aborts any tree
// that visits MAX_DEPTH internal nodes without reaching a leaf, and the
// guard flags the result with out_err.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     config write handshake (accepted only in IDLE)
//   cfg_sel                 0 = node table write, 1 = root table write
//   cfg_addr                node address, or tree index in low TREE_AW bits
//   cfg_data                node word {leaf, fidx, thd, left, right}
//   in_valid/in_ready       feature vector handshake
//   in_data, in_id          packed features (feature i at [i*FEAT_W +: FEAT_W]), ID
//   out_valid/out_ready     result handshake
//   out_class, out_id       majority class and ID of the result
//   out_err                 one or more trees aborted by the depth guard
// -----------------------------------------------------------------------------
module dt_ensemble_engine #(
  parameter int NUM_FEATURE = 8,
  parameter int FEAT_W      = 8,
  parameter int FIDX_W      = 3,
  parameter int NODE_AW     = 8,
  parameter int NUM_TREES   = 4,
  parameter int TREE_AW     = 2,
  parameter int CLASS_W     = 2,
  parameter int MAX_DEPTH   = 16,
  parameter int ID_W        = 12
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic                                      cfg_sel,
  input  logic [NODE_AW-1:0]                        cfg_addr,
  input  logic [1+FIDX_W+FEAT_W+2*NODE_AW-1:0]      cfg_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_FEATURE*FEAT_W-1:0]             in_data,
  input  logic [ID_W-1:0]                           in_id,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CLASS_W-1:0]                        out_class,
  output logic [ID_W-1:0]                           out_id,
  output logic                                      out_err
);

  localparam int NODE_W  = 1 + FIDX_W + FEAT_W + 2 * NODE_AW;
  localparam int NUM_NODE = 1 << NODE_AW;
  localparam int NCLASS  = 1 << CLASS_W;
  localparam int VCNT_W  = $clog2(NUM_TREES + 1);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [NODE_W-1:0]  node_q [NUM_NODE];
  logic [NODE_AW-1:0] root_q [NUM_TREES];

  logic [1:0]                      state_q, state_d;
  logic [TREE_AW-1:0]              tree_q, tree_d;
  logic [NODE_AW-1:0]              nptr_q, nptr_d;
  logic [DEPTH_W-1:0]              depth_q, depth_d;
  logic [NUM_FEATURE*FEAT_W-1:0]   feat_q, feat_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic                            err_q, err_d;
  logic [VCNT_W-1:0]               votes_q [NCLASS];
  logic [VCNT_W-1:0]               votes_d [NCLASS];
  logic                            out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]              out_class_q, out_class_d;
  logic [ID_W-1:0]                 out_id_q, out_id_d;
  logic                            out_err_q, out_err_d;

  // Current node fields (combinational table read).
  logic [NODE_W-1:0]  node_w;
  logic               is_leaf;
  logic [FIDX_W-1:0]  fidx;
  logic [FEAT_W-1:0]  thd;
  logic [NODE_AW-1:0] left_a, right_a;
  logic [CLASS_W-1:0] leaf_cls;
  logic [FEAT_W-1:0]  fsel;
  logic [NODE_AW-1:0] root_next;
  logic [NODE_AW-1:0] root_first;
  logic [TREE_AW-1:0] tree_inc;
  logic               tree_end;
  logic [CLASS_W-1:0] best_c;
  logic [VCNT_W-1:0]  best_v;

  assign node_w   = node_q[nptr_q];
  assign is_leaf  = node_w[NODE_W-1];
  assign fidx     = node_w[NODE_W-2 -: FIDX_W];
  assign thd      = node_w[2*NODE_AW +: FEAT_W];
  assign left_a   = node_w[NODE_AW +: NODE_AW];
  assign right_a  = node_w[0 +: NODE_AW];
  assign leaf_cls = thd[CLASS_W-1:0];
  assign tree_inc = tree_q + 1'b1;

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE) && !cfg_valid;

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;

  // Feature mux; an index past NUM_FEATURE matches nothing and reads as 0.
  always_comb begin
    fsel = '0;
    for (int i = 0; i < NUM_FEATURE; i++) begin
      if (fidx == FIDX_W'(i)) fsel = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  // Root lookups for the first tree and for the tree after the current one.
  always_comb begin
    root_first = root_q[0];
    root_next  = '0;
    for (int t = 0; t < NUM_TREES; t++) begin
      if (tree_inc == TREE_AW'(t)) root_next = root_q[t];
    end
  end

  always_comb begin
    state_d     = state_q;
    tree_d      = tree_q;
    nptr_d      = nptr_q;
    depth_d     = depth_q;
    feat_d      = feat_q;
    id_d        = id_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;
    tree_end    = 1'b0;
    best_c      = '0;
    best_v      = '0;
    for (int c = 0; c < NCLASS; c++) votes_d[c] = votes_q[c];

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          feat_d  = in_data;
          id_d    = in_id;
          tree_d  = '0;
          nptr_d  = root_first;
          depth_d = '0;
          err_d   = 1'b0;
          for (int c = 0; c < NCLASS; c++) votes_d[c] = '0;
          state_d = ST_WALK;
        end
      end

      ST_WALK: begin
        if (is_leaf) begin
          votes_d[leaf_cls] = votes_q[leaf_cls] + 1'b1;
          tree_end = 1'b1;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          // Depth guard: abandon this tree without a vote.
          err_d    = 1'b1;
          tree_end = 1'b1;
        end else begin
          nptr_d  = (fsel <= thd) ? left_a : right_a;
          depth_d = depth_q + 1'b1;
        end

        if (tree_end) begin
          if (tree_q == TREE_AW'(NUM_TREES - 1)) begin
            // Argmax over the final tally; strict > keeps the lowest index on ties.
            best_c = '0;
            best_v = votes_d[0];
            for (int c = 1; c < NCLASS; c++) begin
              if (votes_d[c] > best_v) begin
                best_v = votes_d[c];
                best_c = CLASS_W'(c);
              end
            end
            out_class_d = best_c;
            out_id_d    = id_q;
            out_err_d   = err_d;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            tree_d  = tree_inc;
            nptr_d  = root_next;
            depth_d = '0;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tree_q      <= '0;
      nptr_q      <= '0;
      depth_q     <= '0;
      feat_q      <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
      for (int c = 0; c < NCLASS; c++) votes_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      tree_q      <= tree_d;
      nptr_q      <= nptr_d;
      depth_q     <= depth_d;
      feat_q      <= feat_d;
      id_q        <= id_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
      for (int c = 0; c < NCLASS; c++) votes_q[c] <= votes_d[c];
    end
  end

  // Node and root tables. Root indices beyond NUM_TREES-1 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NODE; n++) node_q[n] <= '0;
      for (int t = 0; t < NUM_TREES; t++) root_q[t] <= '0;
    end else if (cfg_valid && cfg_ready) begin
      if (cfg_sel) begin
        for (int t = 0; t < NUM_TREES; t++) begin
          if (cfg_addr[TREE_AW-1:0] == TREE_AW'(t)) root_q[t] <= cfg_data[NODE_AW-1:0];
        end
      end else begin
        node_q[cfg_addr] <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_dt_ensemble_engine.sv
module tb_dt_ensemble_engine;

  localparam int NUM_FEATURE = 8;
  localparam int FEAT_W      = 8;
  localparam int FIDX_W      = 3;
  localparam int NODE_AW     = 8;
  localparam int NUM_TREES   = 4;
  localparam int TREE_AW     = 2;
  localparam int CLASS_W     = 2;
  localparam int MAX_DEPTH   = 16;
  localparam int ID_W        = 12;
  localparam int NODE_W      = 1 + FIDX_W + FEAT_W + 2 * NODE_AW;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          cfg_valid = 1'b0;
  logic                          cfg_ready;
  logic                          cfg_sel = 1'b0;
  logic [NODE_AW-1:0]            cfg_addr = '0;
  logic [NODE_W-1:0]             cfg_data = '0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [NUM_FEATURE*FEAT_W-1:0] in_data = '0;
  logic [ID_W-1:0]               in_id = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b0;
  logic [CLASS_W-1:0]            out_class;
  logic [ID_W-1:0]               out_id;
  logic                          out_err;

  dt_ensemble_engine #(
    .NUM_FEATURE(NUM_FEATURE), .FEAT_W(FEAT_W), .FIDX_W(FIDX_W), .NODE_AW(NODE_AW),
    .NUM_TREES(NUM_TREES), .TREE_AW(TREE_AW), .CLASS_W(CLASS_W),
    .MAX_DEPTH(MAX_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_id(out_id), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;   // 0 = leaf roots, 1 = stump, 2 = depth guard
    logic [1:0]  c0, c1, c2, c3;
    logic [7:0]  f3;
    logic [11:0] id;
    logic [1:0]  ecls;
    logic        eerr;
    int          ecyc;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk(input logic leaf, input logic [2:0] fidx,
                                           input logic [7:0] thd, input logic [7:0] l,
                                           input logic [7:0] r);
    return {leaf, fidx, thd, l, r};
  endfunction

  function automatic vec_t mkv(input int kind, input logic [1:0] c0, input logic [1:0] c1,
                               input logic [1:0] c2, input logic [1:0] c3, input logic [7:0] f3,
                               input logic [11:0] id, input logic [1:0] ecls,
                               input logic eerr, input int ecyc);
    vec_t v;
    v.kind = kind; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.f3 = f3;
    v.id = id; v.ecls = ecls; v.eerr = eerr; v.ecyc = ecyc;
    return v;
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic cfg_wr(input logic sel, input int addr, input logic [NODE_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = NODE_AW'(addr);
    cfg_data  = d;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    logic [1:0] cl [4];
    cl[0] = v.c0; cl[1] = v.c1; cl[2] = v.c2; cl[3] = v.c3;
    if (v.kind == 0) begin
      for (int t = 0; t < 4; t++) begin
        cfg_wr(1'b0, 10 + t, mk(1'b1, 3'd0, {6'd0, cl[t]}, 8'd0, 8'd0));
        cfg_wr(1'b1, t, NODE_W'(10 + t));
      end
    end else if (v.kind == 1) begin
      cfg_wr(1'b0, 2, mk(1'b0, 3'd3, 8'd100, 8'd4, 8'd5));
      cfg_wr(1'b0, 4, mk(1'b1, 3'd0, 8'd0, 8'd0, 8'd0));
      cfg_wr(1'b0, 5, mk(1'b1, 3'd0, 8'd2, 8'd0, 8'd0));
      for (int t = 0; t < 4; t++) cfg_wr(1'b1, t, NODE_W'(2));
    end else begin
      cfg_wr(1'b0, 7, mk(1'b0, 3'd0, 8'd0, 8'd7, 8'd7));
      cfg_wr(1'b0, 14, mk(1'b1, 3'd0, 8'd2, 8'd0, 8'd0));
      cfg_wr(1'b1, 0, NODE_W'(7));
      for (int t = 1; t < 4; t++) cfg_wr(1'b1, t, NODE_W'(14));
    end
  endtask

  task automatic start(input logic [7:0] f3, input logic [11:0] id);
    in_data = 64'h0807060504030201;
    in_data[3*FEAT_W +: FEAT_W] = f3;
    in_id    = id;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [7:0] f3, input logic [11:0] id,
                           input logic [1:0] ecls, input logic eerr, input int ecyc);
    int cyc;
    start(f3, id);
    chk({nm, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_out(nm, cyc);
    chk({nm, "_cycles"}, 32'(cyc), 32'(ecyc));
    chk({nm, "_class"}, 32'(out_class), 32'(ecls));
    chk({nm, "_id"}, 32'(out_id), 32'(id));
    chk({nm, "_err"}, 32'(out_err), 32'(eerr));
    release_out();
  endtask

  initial begin
    vt[0] = mkv(0, 2'd1, 2'd1, 2'd2, 2'd3, 8'd0,   12'h5A5, 2'd1, 1'b0, 4);
    vt[1] = mkv(0, 2'd3, 2'd3, 2'd1, 2'd1, 8'd0,   12'h101, 2'd1, 1'b0, 4);
    vt[2] = mkv(0, 2'd0, 2'd2, 2'd2, 2'd1, 8'd0,   12'h202, 2'd2, 1'b0, 4);
    vt[3] = mkv(0, 2'd3, 2'd3, 2'd3, 2'd0, 8'd0,   12'h303, 2'd3, 1'b0, 4);
    vt[4] = mkv(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'd100, 12'h404, 2'd0, 1'b0, 8);
    vt[5] = mkv(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'd101, 12'h505, 2'd2, 1'b0, 8);
    vt[6] = mkv(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'd255, 12'h606, 2'd2, 1'b0, 8);
    vt[7] = mkv(2, 2'd0, 2'd0, 2'd0, 2'd0, 8'd0,   12'hABC, 2'd2, 1'b1, 20);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // Unconfigured tables: every tree aborts after MAX_DEPTH+1 cycles
    run_check("unconf", 8'd0, 12'h011, 2'd0, 1'b1, 4 * (MAX_DEPTH + 1));

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      setup(vt[i]);
      run_check($sformatf("vec%0d", i), vt[i].f3, vt[i].id, vt[i].ecls, vt[i].eerr, vt[i].ecyc);
    end

    // Backpressure: result held while out_ready is low
    begin
      int cyc;
      setup(vt[0]);
      start(8'd0, 12'h3C3);
      wait_out("bp", cyc);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
        chk($sformatf("bp_hold_class%0d", k), 32'(out_class), 32'd1);
        chk($sformatf("bp_hold_id%0d", k), 32'(out_id), 32'h3C3);
        chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
        chk($sformatf("bp_cfg_ready%0d", k), 32'(cfg_ready), 32'd0);
      end
      release_out();
      chk("bp_valid_drop", 32'(out_valid), 32'd0);
      chk("bp_in_ready_back", 32'(in_ready), 32'd1);
      chk("bp_class_kept", 32'(out_class), 32'd1);
      chk("bp_id_kept", 32'(out_id), 32'h3C3);
    end

    // Config wins over a simultaneous vector
    setup(mkv(0, 2'd0, 2'd1, 2'd2, 2'd3, 8'd0, 12'd0, 2'd0, 1'b0, 0));
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_addr = 8'd0; cfg_data = NODE_W'(11);
    in_valid = 1'b1; in_id = 12'h123;
    #1;
    chk("sim_in_ready", 32'(in_ready), 32'd0);
    chk("sim_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0; in_valid = 1'b0;
    #1;
    chk("sim_still_idle", 32'(in_ready), 32'd1);
    chk("sim_no_out", 32'(out_valid), 32'd0);
    // Root 0 now points at leaf 11 (class 1): votes 1,1,2,3 -> class 1
    run_check("sim_after", 8'd0, 12'h124, 2'd1, 1'b0, 4);

    // Reset mid-WALK
    setup(vt[7]);
    start(8'd0, 12'h777);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_id", 32'(out_id), 32'd0);
    chk("mrst_out_class", 32'(out_class), 32'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("mrst_no_result", 32'(seen), 32'd0);
    end
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    run_check("mrst_fresh", 8'd0, 12'h0F0, 2'd0, 1'b1, 4 * (MAX_DEPTH + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
